// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and defaults for the bit-serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - combinational one-bit full adder from two half-adder stages
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  assign ha0_s = a ^ b;
  assign ha0_c = a & b;
  assign s     = ha0_s ^ ci;
  assign ha1_c = ha0_s & ci;
  assign co    = ha0_c | ha1_c;

endmodule

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - WIDTH-cycle bit-serial adder with valid/ready on both sides
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module bit_serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  full_adder_cell u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  // Gated by state so nothing partial is visible while shifting.
  assign sum_out   = out_valid ? sum_sh_q : '0;
  assign cout      = out_valid & carry_q;

`ifdef SERIAL_ADDER_OVF_EN
  logic cmsb_q, cmsb_d;

  always_comb begin
    cmsb_d = cmsb_q;
    if (last_bit) begin
      cmsb_d = carry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmsb_q <= 1'b0;
    end else begin
      cmsb_q <= cmsb_d;
    end
  end

  assign ovf = out_valid & (cmsb_q ^ carry_q);
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb/tb_bit_serial_adder.sv - scoreboard bench for bit_serial_adder (WIDTH=8)
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum_out;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  mon_e;
  bit          b2b = 1'b0;
  int          prev_hs = -1;
  int          lat;
  int          ok;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {ovf, cout, sum}: overflow when both operands share a sign the result lacks.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] s;
    logic       v;
    s = {1'b0, a} + {1'b0, b} + {8'd0, c};
    v = (a[7] == b[7]) && (s[7] != a[7]);
    return {v, s};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sum", 64'(sum_out), 64'(mon_e[7:0]));
        chk("cout", 64'(cout), 64'(mon_e[8]));
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", 64'(ovf), 64'(mon_e[9]));
`endif
        if (b2b) begin
          if (prev_hs >= 0) chk("interval", 64'(cyc - prev_hs), 64'd10);
          prev_hs = cyc;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic c);
    a_in = a;
    b_in = b;
    cin = c;
    in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) chk("accept_timeout", 64'd0, 64'd1);
    else exp_q.push_back(model(a, b, c));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_valid(output int n);
    n = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
    accept(a, b, c);
    wait_valid(lat);
    chk(tag, 64'(lat), 64'd8);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", 64'(sum_out), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", 64'(ovf), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op(8'h35, 8'h0A, 1'b0, "latency_35_0a");
    run_op(8'hFF, 8'h01, 1'b0, "latency_ff_01");
    run_op(8'h7F, 8'h01, 1'b0, "latency_7f_01");

    out_ready = 1'b0;
    accept(8'h10, 8'h20, 1'b0);
    wait_valid(lat);
    chk("latency_10_20", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      chk("hold_sum", 64'(sum_out), 64'h30);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_hs", 64'(in_ready), 64'd1);
    chk("busy_after_hs", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    accept(8'hAA, 8'h55, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_sum", 64'(sum_out), 64'd0);
    chk("midrst_cout", 64'(cout), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(8'h01, 8'h01, 1'b1, "latency_after_rst");

    b2b = 1'b1;
    prev_hs = -1;
    out_ready = 1'b1;
    a_in = 8'($urandom);
    b_in = 8'($urandom);
    cin = 1'($urandom);
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ok = 0;
      for (int j = 0; j < 40; j++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1;
          break;
        end
      end
      if (ok == 0) begin
        chk("b2b_accept_timeout", 64'd0, 64'd1);
        break;
      end
      exp_q.push_back(model(a_in, b_in, cin));
      @(posedge clk);
      #1;
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      cin = 1'($urandom);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #2;
    b2b = 1'b0;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
